mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one SRAM-like memory port (addr_ok/data_ok handshake) between instruction fetch and
//  the EX-stage data access (inst_sram_*, data_sram_*). Data has priority. Raises per-requester
//  stall requests into the stall controller and holds read data until the pipeline advances.
// PARAMETERS
//  AW  32  address width
//  DW  32  data width; byte strobes are DW/8
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous, active-high reset
//  flush          in   1     pipeline flush; discard pending and in-flight results
//  stall_all      in   1     global stall active this cycle; done flags clear only when 0
//  inst_en        in   1     fetch request (read)
//  inst_addr      in   AW    fetch address
//  inst_rdata     out  DW    buffered fetch data, valid while inst_done
//  inst_stallreq  out  1     inst_en & ~inst_done
//  data_en        in   1     data request
//  data_wen       in   DW/8  byte write enables; 0 = read
//  data_addr      in   AW    data address
//  data_wdata     in   DW    store data
//  data_rdata     out  DW    buffered load data, valid while data_done
//  data_stallreq  out  1     data_en & ~data_done
//  mem_req        out  1     shared-port request, held until mem_addr_ok
//  mem_wr         out  1     1 = write
//  mem_wstrb      out  DW/8  byte strobes (latched data_wen)
//  mem_addr       out  AW    latched address
//  mem_wdata      out  DW    latched store data
//  mem_addr_ok    in   1     address accepted (qualified by mem_req)
//  mem_data_ok    in   1     read data valid / write complete
//  mem_rdata      in   DW    read data
// BEHAVIOUR
//  States: IDLE, D_ADDR, D_DATA, I_ADDR, I_DATA. Reset -> IDLE; mem_req=0, mem_wr=0,
//   mem_wstrb/addr/wdata=0, inst_done=data_done=0, inst_rdata=data_rdata=0, discard=0.
//  Pending: data_pend = data_en & ~data_done; inst_pend = inst_en & ~inst_done.
//  IDLE: data_pend -> latch addr/wen/wdata, go D_ADDR; else inst_pend -> latch inst_addr,
//   mem_wr=0, wstrb=0, go I_ADDR. Both pending same cycle: data wins, inst waits.
//  x_ADDR: mem_req=1, all mem_* outputs stable from registers; on mem_addr_ok -> x_DATA
//   (mem_req=0 the next cycle). Request is never withdrawn before addr_ok, even on flush.
//  x_DATA: mem_req=0; on mem_data_ok -> IDLE; unless discard, x_done<=1 and (reads)
//   x_rdata<=mem_rdata. Writes set data_done on data_ok; data_rdata unchanged.
//  Min latency: request seen cycle N, mem_req N+1, addr_ok N+1, data_ok N+2, done and
//   stallreq=0 at N+3. Slower addr_ok/data_ok extend x_ADDR/x_DATA indefinitely.
//  Done flags: clear on the first cycle with stall_all=0 (stage advanced); hold while
//   stall_all=1 so rdata stays stable for a stalled consumer. One transaction per done.
//  flush: clears inst_done and data_done; if FSM not IDLE, set discard; discard clears on
//   the data_ok that ends the in-flight transaction (result dropped, no done).
//  mem_addr_ok/mem_data_ok outside x_ADDR/x_DATA respectively are ignored.
//  Reset mid-transaction: immediate IDLE, mem_req=0; late data_ok ignored.
//  Only one outstanding transaction; next one is never issued in the cycle data_ok arrives.
// TESTING
//  inst_en=1 addr=0xBFC00000, mem: addr_ok immediate, data_ok +1 rdata=0x3C08BFAF ->
//   mem_req 1 cycle, inst_stallreq high 3 cycles, inst_rdata=0x3C08BFAF.
//  inst_en & data_en (wen=4'hF, addr=0x80001000, wdata=0xDEADBEEF) same cycle -> write
//   issued first (mem_wr=1, wstrb=F), fetch issued after its data_ok; inst stalls longer.
//  addr_ok delayed 3 cycles -> mem_req held 4 cycles, mem_addr/mem_wdata constant throughout.
//  stall_all=1 for 5 cycles after data_done -> data_rdata and data_done held; clear on
//   first stall_all=0 cycle; no second request issued while done.
//  flush in I_DATA -> data_ok rdata=0x12345678 not captured, inst_done stays 0, next
//   inst_en re-issues a fresh fetch.
//  rst in D_ADDR -> next cycle mem_req=0, state IDLE, all outputs at reset values.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one SRAM-like memory port (addr_ok/data_ok handshake) between instruction
// fetch and EX-stage data access; data has priority, results held until the stage advances.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            stall_all,
  input  logic            inst_en,
  input  logic [AW-1:0]   inst_addr,
  output logic [DW-1:0]   inst_rdata,
  output logic            inst_stallreq,
  input  logic            data_en,
  input  logic [DW/8-1:0] data_wen,
  input  logic [AW-1:0]   data_addr,
  input  logic [DW-1:0]   data_wdata,
  output logic [DW-1:0]   data_rdata,
  output logic            data_stallreq,
  output logic            mem_req,
  output logic            mem_wr,
  output logic [DW/8-1:0] mem_wstrb,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic            mem_addr_ok,
  input  logic            mem_data_ok,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int SW = DW / 8;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_D_ADDR = 3'd1;
  localparam logic [2:0] S_D_DATA = 3'd2;
  localparam logic [2:0] S_I_ADDR = 3'd3;
  localparam logic [2:0] S_I_DATA = 3'd4;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic          r_mem_wr;
  logic [SW-1:0] r_mem_wstrb;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_inst_done;
  logic          r_data_done;
  logic [DW-1:0] r_inst_rdata;
  logic [DW-1:0] r_data_rdata;
  logic          r_discard;

  logic w_data_pend;
  logic w_inst_pend;
  logic w_idle_issue;
  logic w_end_txn;
  logic w_keep;
  logic w_keep_data;
  logic w_keep_inst;

  assign w_data_pend  = data_en & ~r_data_done;
  assign w_inst_pend  = inst_en & ~r_inst_done;
  // A flush in IDLE drops whatever the flushed stages were asking for.
  assign w_idle_issue = (r_state == S_IDLE) & ~flush;

  assign w_end_txn   = mem_data_ok & ((r_state == S_D_DATA) | (r_state == S_I_DATA));
  // A flush arriving together with data_ok still drops that result.
  assign w_keep      = w_end_txn & ~r_discard & ~flush;
  assign w_keep_data = w_keep & (r_state == S_D_DATA);
  assign w_keep_inst = w_keep & (r_state == S_I_DATA);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_idle_issue && w_data_pend)      w_state_nxt = S_D_ADDR;
        else if (w_idle_issue && w_inst_pend) w_state_nxt = S_I_ADDR;
      end
      S_D_ADDR: if (mem_addr_ok) w_state_nxt = S_D_DATA;
      S_D_DATA: if (mem_data_ok) w_state_nxt = S_IDLE;
      S_I_ADDR: if (mem_addr_ok) w_state_nxt = S_I_DATA;
      S_I_DATA: if (mem_data_ok) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_mem_wr     <= 1'b0;
      r_mem_wstrb  <= '0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_inst_rdata <= '0;
      r_data_rdata <= '0;
      r_discard    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;

      if (w_idle_issue && w_data_pend) begin
        r_mem_wr    <= |data_wen;
        r_mem_wstrb <= data_wen;
        r_mem_addr  <= data_addr;
        r_mem_wdata <= data_wdata;
      end else if (w_idle_issue && w_inst_pend) begin
        r_mem_wr    <= 1'b0;
        r_mem_wstrb <= '0;
        r_mem_addr  <= inst_addr;
      end

      if (w_end_txn)
        r_discard <= 1'b0;
      else if (flush && (r_state != S_IDLE))
        r_discard <= 1'b1;

      if (flush)            r_data_done <= 1'b0;
      else if (w_keep_data) r_data_done <= 1'b1;
      else if (!stall_all)  r_data_done <= 1'b0;

      if (flush)            r_inst_done <= 1'b0;
      else if (w_keep_inst) r_inst_done <= 1'b1;
      else if (!stall_all)  r_inst_done <= 1'b0;

      if (w_keep_data && !r_mem_wr) r_data_rdata <= mem_rdata;
      if (w_keep_inst)              r_inst_rdata <= mem_rdata;
    end
  end

  assign mem_req       = (r_state == S_D_ADDR) | (r_state == S_I_ADDR);
  assign mem_wr        = r_mem_wr;
  assign mem_wstrb     = r_mem_wstrb;
  assign mem_addr      = r_mem_addr;
  assign mem_wdata     = r_mem_wdata;
  assign inst_rdata    = r_inst_rdata;
  assign data_rdata    = r_data_rdata;
  assign inst_stallreq = w_inst_pend;
  assign data_stallreq = w_data_pend;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle-by-cycle bench for mem_port_arbiter; the memory side is driven by hand.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst, flush, stall_all;
  logic        inst_en;
  logic [31:0] inst_addr, inst_rdata;
  logic        inst_stallreq;
  logic        data_en;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_stallreq;
  logic        mem_req, mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int checks = 0;
  int failures = 0;

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall_all(stall_all),
    .inst_en(inst_en), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
    .inst_stallreq(inst_stallreq),
    .data_en(data_en), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_stallreq(data_stallreq),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_all = 1'b0;
    inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    tick; tick;
    rst = 1'b0;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_inst_rdata", inst_rdata, 32'd0);
    chk("rst_data_rdata", data_rdata, 32'd0);
    tick;

    // Single fetch, minimum latency
    inst_en = 1'b1; inst_addr = 32'hBFC00000;
    #1;
    chk("f1_stall_n0", 32'(inst_stallreq), 32'd1);
    chk("f1_req_n0", 32'(mem_req), 32'd0);
    tick;
    chk("f1_req_n1", 32'(mem_req), 32'd1);
    chk("f1_addr_n1", mem_addr, 32'hBFC00000);
    chk("f1_wr_n1", 32'(mem_wr), 32'd0);
    chk("f1_stall_n1", 32'(inst_stallreq), 32'd1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    chk("f1_req_n2", 32'(mem_req), 32'd0);
    chk("f1_stall_n2", 32'(inst_stallreq), 32'd1);
    mem_data_ok = 1'b1; mem_rdata = 32'h3C08BFAF;
    tick;
    mem_data_ok = 1'b0;
    chk("f1_stall_n3", 32'(inst_stallreq), 32'd0);
    chk("f1_rdata_n3", inst_rdata, 32'h3C08BFAF);
    chk("f1_req_n3", 32'(mem_req), 32'd0);
    inst_en = 1'b0;
    tick;
    chk("f1_req_n4", 32'(mem_req), 32'd0);

    // Data write and fetch requested together: write goes first
    inst_en = 1'b1; inst_addr = 32'hBFC00004;
    data_en = 1'b1; data_wen = 4'hF; data_addr = 32'h80001000; data_wdata = 32'hDEADBEEF;
    tick;
    chk("pr_req_d", 32'(mem_req), 32'd1);
    chk("pr_wr_d", 32'(mem_wr), 32'd1);
    chk("pr_wstrb_d", 32'(mem_wstrb), 32'hF);
    chk("pr_addr_d", mem_addr, 32'h80001000);
    chk("pr_wdata_d", mem_wdata, 32'hDEADBEEF);
    chk("pr_istall_d", 32'(inst_stallreq), 32'd1);
    chk("pr_dstall_d", 32'(data_stallreq), 32'd1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    chk("pr_req_ddata", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'h55555555;
    tick;
    mem_data_ok = 1'b0;
    chk("pr_dstall_done", 32'(data_stallreq), 32'd0);
    chk("pr_istall_wait", 32'(inst_stallreq), 32'd1);
    chk("pr_req_gap", 32'(mem_req), 32'd0);
    chk("pr_wr_rdata_kept", data_rdata, 32'd0);
    data_en = 1'b0; data_wen = 4'h0;
    tick;
    chk("pr_req_i", 32'(mem_req), 32'd1);
    chk("pr_wr_i", 32'(mem_wr), 32'd0);
    chk("pr_wstrb_i", 32'(mem_wstrb), 32'd0);
    chk("pr_addr_i", mem_addr, 32'hBFC00004);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h24020001;
    tick;
    mem_data_ok = 1'b0;
    chk("pr_istall_done", 32'(inst_stallreq), 32'd0);
    chk("pr_irdata", inst_rdata, 32'h24020001);
    inst_en = 1'b0;
    tick;

    // Read with addr_ok delayed 3 cycles, then held result under stall_all
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h80002000; data_wdata = 32'hCAFEF00D;
    tick;
    for (int i = 0; i < 3; i++) begin
      chk("dl_req_wait", 32'(mem_req), 32'd1);
      chk("dl_addr_wait", mem_addr, 32'h80002000);
      chk("dl_wdata_wait", mem_wdata, 32'hCAFEF00D);
      chk("dl_wr_wait", 32'(mem_wr), 32'd0);
      tick;
    end
    chk("dl_req_4th", 32'(mem_req), 32'd1);
    chk("dl_addr_4th", mem_addr, 32'h80002000);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    chk("dl_req_dropped", 32'(mem_req), 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'hA5A55A5A; stall_all = 1'b1;
    tick;
    mem_data_ok = 1'b0;
    chk("dl_dstall_done", 32'(data_stallreq), 32'd0);
    chk("dl_rdata", data_rdata, 32'hA5A55A5A);
    tick;
    for (int i = 0; i < 5; i++) begin
      chk("st_rdata_held", data_rdata, 32'hA5A55A5A);
      chk("st_done_held", 32'(data_stallreq), 32'd0);
      chk("st_no_req", 32'(mem_req), 32'd0);
      tick;
    end
    stall_all = 1'b0;
    tick;
    chk("st_done_cleared", 32'(data_stallreq), 32'd1);
    chk("st_rdata_after", data_rdata, 32'hA5A55A5A);
    data_en = 1'b0;
    tick;
    chk("st_no_reissue", 32'(mem_req), 32'd0);

    // Flush while fetch is in its data phase
    inst_en = 1'b1; inst_addr = 32'hBFC00100;
    tick;
    chk("fl_req", 32'(mem_req), 32'd1);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("fl_stall_a", 32'(inst_stallreq), 32'd1);
    mem_data_ok = 1'b1; mem_rdata = 32'h12345678;
    tick;
    mem_data_ok = 1'b0;
    chk("fl_stall_b", 32'(inst_stallreq), 32'd1);
    chk("fl_rdata_dropped", inst_rdata, 32'h24020001);
    chk("fl_req_idle", 32'(mem_req), 32'd0);
    tick;
    chk("fl_reissue_req", 32'(mem_req), 32'd1);
    chk("fl_reissue_addr", mem_addr, 32'hBFC00100);
    mem_addr_ok = 1'b1;
    tick;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h8C020000;
    tick;
    mem_data_ok = 1'b0;
    chk("fl_refetch_rdata", inst_rdata, 32'h8C020000);
    chk("fl_refetch_stall", 32'(inst_stallreq), 32'd0);
    inst_en = 1'b0;
    tick;

    // Reset in the middle of a data address phase
    data_en = 1'b1; data_wen = 4'h3; data_addr = 32'h80003000; data_wdata = 32'h11223344;
    tick;
    chk("rs_req", 32'(mem_req), 32'd1);
    chk("rs_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1; data_en = 1'b0; data_wen = 4'h0;
    tick;
    rst = 1'b0;
    chk("rs_req_off", 32'(mem_req), 32'd0);
    chk("rs_wr_off", 32'(mem_wr), 32'd0);
    chk("rs_wstrb_off", 32'(mem_wstrb), 32'd0);
    chk("rs_addr_off", mem_addr, 32'd0);
    chk("rs_wdata_off", mem_wdata, 32'd0);
    chk("rs_irdata_off", inst_rdata, 32'd0);
    chk("rs_drdata_off", data_rdata, 32'd0);
    mem_data_ok = 1'b1; mem_rdata = 32'hFFFF0000;
    tick;
    mem_data_ok = 1'b0;
    chk("rs_late_ok_ignored", data_rdata, 32'd0);
    chk("rs_late_req", 32'(mem_req), 32'd0);
    chk("rs_late_dstall", 32'(data_stallreq), 32'd0);
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
